// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction fetch front end with a small prefetch queue. Requests are
//   issued to instruction memory as long as queue space is guaranteed for
//   every response (queued + in-flight < DEPTH). Responses are pushed into
//   a shift-style queue whose entry 0 is always the head. The decode-facing
//   outputs therefore come straight from dedicated head registers. A redirect
//   flushes the queue and discards responses to requests that are still in
//   flight.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
//   imem_req_ready are both 1. Once raised, imem_req_valid/imem_req_addr stay
//   stable until that transfer. The only exception is a redirect, which
//   withdraws the request. Responses carry no ready: one word per
//   imem_rsp_valid cycle, in request order.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   imem_req_*          : fetch request (valid/ready/addr)
//   imem_rsp_*          : fetch response (valid/data)
//   stall_f             : decode holds the current head
//   redirect_valid/_pc  : taken branch/jump and its target
//   instr_f, pc_f,
//   pcplus4_f,
//   instr_valid_f       : queue head (NOP when empty)
//   queue_count         : occupied queue entries
//   dbg_state           : FSM state (0 = FETCH, 1 = DRAIN)
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     stall_f,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              instr_f,
  output logic [31:0]              pc_f,
  output logic [31:0]              pcplus4_f,
  output logic                     instr_valid_f,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     dbg_state
);

  localparam int          CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_rsp_pc;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_discard_cnt;
  logic [CNT_W-1:0]   w_discard_nxt;
  logic [31:0]        r_q_data [DEPTH];
  logic [31:0]        r_q_pc   [DEPTH];

  logic               w_accept;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W:0]     w_credit_sum;
  logic [CNT_W-1:0]   w_push_idx;
  logic [DEPTH-1:0]   w_wr_en;

  // A response only counts if something is actually in flight; stray
  // responses (e.g. to requests abandoned by reset) are ignored.
  assign w_accept     = imem_req_valid & imem_req_ready;
  assign w_rsp        = imem_rsp_valid & (r_outstanding != '0);
  assign w_push       = w_rsp & ~redirect_valid & (r_state == ST_FETCH);
  assign w_pop        = (r_count != '0) & ~stall_f & ~redirect_valid;
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};

  // Queue + in-flight can only grow through an accepted request, so once
  // valid is raised it cannot fall again before acceptance (except redirect).
  assign imem_req_valid = reset & ~redirect_valid & (w_credit_sum < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  // Head lives in entry 0; when popping, the tail slot moves down by one.
  assign w_push_idx = w_pop ? (r_count - CNT_W'(1)) : r_count;

  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_en[i] = w_push && (w_push_idx == CNT_W'(i));
    end
  end

  // FSM next state and discard counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard_cnt;
    if (redirect_valid) begin
      // A response arriving in the redirect cycle is itself stale and is
      // consumed here, so it is not counted again.
      w_discard_nxt = r_outstanding - CNT_W'(w_rsp);
      w_state_nxt   = (w_discard_nxt != '0) ? ST_DRAIN : ST_FETCH;
    end else if ((r_state == ST_DRAIN) && w_rsp) begin
      w_discard_nxt = r_discard_cnt - CNT_W'(1);
      if (w_discard_nxt == '0) begin
        w_state_nxt = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_discard_cnt <= '0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_discard_cnt <= w_discard_nxt;
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);

      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        r_count    <= '0;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)   r_rsp_pc   <= r_rsp_pc + 32'd4;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Queue storage needs no reset: occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_q_data[i] <= r_q_data[i+1];
        r_q_pc[i]   <= r_q_pc[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en[i]) begin
        r_q_data[i] <= imem_rsp_data;
        r_q_pc[i]   <= r_rsp_pc;
      end
    end
  end

  // When empty, pc_f shows the PC the next pushed instruction will carry.
  assign instr_valid_f = (r_count != '0);
  assign instr_f       = instr_valid_f ? r_q_data[0] : NOP;
  assign pc_f          = instr_valid_f ? r_q_pc[0]   : r_rsp_pc;
  assign pcplus4_f     = pc_f + 32'd4;
  assign queue_count   = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h1000_0000;  // memory word = addr + OFS

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        stall_f        = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic [31:0] instr_f, pc_f, pcplus4_f;
  logic        instr_valid_f;
  logic [2:0]  queue_count;
  logic        dbg_state;

  // second instance for the PC wrap case
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = 32'h0;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic        w_ivalid;
  logic [2:0]  w_count;
  logic        w_dbg;
  logic        w_ready    = 1'b1;
  logic        w_stall    = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redir_pc = 32'h0;

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_f(stall_f), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f),
    .instr_valid_f(instr_valid_f), .queue_count(queue_count), .dbg_state(dbg_state)
  );

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .stall_f(w_stall), .redirect_valid(w_redirect), .redirect_pc(w_redir_pc),
    .instr_f(w_instr), .pc_f(w_pc), .pcplus4_f(w_pc4),
    .instr_valid_f(w_ivalid), .queue_count(w_count), .dbg_state(w_dbg)
  );

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- memory model / driver ----------------
  logic [31:0] pend[$];       // accepted, not yet answered addresses
  logic [31:0] exp_q[$];      // expected pc stream
  bit          mem_hold = 1'b0;
  logic        acc, acc2;
  logic [31:0] acc_addr, acc2_addr;

  // One clock: sample handshakes before the edge, update responders after.
  task automatic tick();
    #1;
    acc       = imem_req_valid & imem_req_ready;
    acc_addr  = imem_req_addr;
    acc2      = w_req_valid;
    acc2_addr = w_req_addr;
    @(posedge clk);
    #1;
    if (acc) pend.push_back(acc_addr);
    if (!mem_hold && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend.pop_front() + OFS;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    w_rsp_valid = acc2;
    w_rsp_data  = acc2_addr + OFS;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    pend.delete();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick(); tick();
    n_total++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got=%h exp=0", imem_req_valid); end
    n_total++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr got=%h exp=0", imem_req_addr); end
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL rst_ivalid got=%h exp=0", instr_valid_f); end
    n_total++; if (instr_f !== NOP) begin n_bad++; $display("FAIL rst_instr got=%h exp=%h", instr_f, NOP); end
    n_total++; if (pc_f !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=0", pc_f); end
    n_total++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
    n_total++; if (w_pc !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL rst_wrap_pc got=%h exp=fffffff8", w_pc); end
    n_total++; if (w_req_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL rst_wrap_addr got=%h exp=fffffff8", w_req_addr); end
    reset = 1'b1;
    #1;
    n_total++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rel_req_valid got=%h exp=1", imem_req_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    tick();
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL stream_c2_ivalid got=%h exp=0", instr_valid_f); end
    tick();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_total++; if (instr_valid_f !== 1'b1) begin n_bad++; $display("FAIL stream_ivalid[%0d] got=%h exp=1", k, instr_valid_f); end
      n_total++; if (pc_f !== e) begin n_bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, pc_f, e); end
      n_total++; if (instr_f !== e + OFS) begin n_bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, instr_f, e + OFS); end
      n_total++; if (pcplus4_f !== e + 32'd4) begin n_bad++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", k, pcplus4_f, e + 32'd4); end
      n_total++; if (queue_count !== 3'd1) begin n_bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, queue_count); end
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] e;
    do_reset();
    stall_f = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    n_total++; if (queue_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", queue_count); end
    n_total++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid got=%h exp=0", imem_req_valid); end
    stall_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = 32'(k) * 32'd4;
      n_total++; if (pc_f !== e) begin n_bad++; $display("FAIL full_pop_pc[%0d] got=%h exp=%h", k, pc_f, e); end
      n_total++; if (instr_f !== e + OFS) begin n_bad++; $display("FAIL full_pop_instr[%0d] got=%h exp=%h", k, instr_f, e + OFS); end
      tick();
    end
    n_total++; if (pc_f !== 32'h10) begin n_bad++; $display("FAIL full_after_pc got=%h exp=10", pc_f); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    mem_hold = 1'b1;
    tick();                 // accept 0
    tick();                 // accept 4
    mem_hold = 1'b0;
    tick();                 // accept 8, response for 0 now on the bus
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL redir_count got=%0d exp=0", queue_count); end
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL redir_ivalid got=%h exp=0", instr_valid_f); end
    n_total++; if (dbg_state !== 1'b1) begin n_bad++; $display("FAIL redir_state got=%h exp=1", dbg_state); end
    tick();                 // response for 4 dropped
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL drain1_ivalid got=%h exp=0", instr_valid_f); end
    tick();                 // response for 8 dropped
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL drain2_ivalid got=%h exp=0", instr_valid_f); end
    n_total++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL drain_done_state got=%h exp=0", dbg_state); end
    tick();                 // response for 100 pushed
    n_total++; if (instr_valid_f !== 1'b1) begin n_bad++; $display("FAIL redir_first_ivalid got=%h exp=1", instr_valid_f); end
    n_total++; if (pc_f !== 32'h100) begin n_bad++; $display("FAIL redir_first_pc got=%h exp=100", pc_f); end
    n_total++; if (instr_f !== 32'h1000_0100) begin n_bad++; $display("FAIL redir_first_instr got=%h exp=10000100", instr_f); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    stall_f = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_total++; if (queue_count !== 3'd4) begin n_bad++; $display("FAIL rfull_pre_count got=%0d exp=4", queue_count); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL rfull_ivalid got=%h exp=0", instr_valid_f); end
    n_total++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL rfull_count got=%0d exp=0", queue_count); end
    n_total++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rfull_req_valid got=%h exp=1", imem_req_valid); end
    n_total++; if (imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL rfull_req_addr got=%h exp=200", imem_req_addr); end
    stall_f = 1'b0;
    tick();
    tick();
    n_total++; if (pc_f !== 32'h200) begin n_bad++; $display("FAIL rfull_first_pc got=%h exp=200", pc_f); end
    n_total++; if (instr_f !== 32'h1000_0200) begin n_bad++; $display("FAIL rfull_first_instr got=%h exp=10000200", instr_f); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    tick();
    n_total++; if (w_pc !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w_pc); end
    n_total++; if (w_instr !== 32'h0FFF_FFF8) begin n_bad++; $display("FAIL wrap_instr0 got=%h exp=0ffffff8", w_instr); end
    n_total++; if (w_pc4 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc4_0 got=%h exp=fffffffc", w_pc4); end
    tick();
    n_total++; if (w_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", w_pc); end
    n_total++; if (w_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4_1 got=%h exp=0", w_pc4); end
    tick();
    n_total++; if (w_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc2 got=%h exp=0", w_pc); end
    n_total++; if (w_instr !== 32'h1000_0000) begin n_bad++; $display("FAIL wrap_instr2 got=%h exp=10000000", w_instr); end
  endtask

  task automatic test_stray_rsp();
    do_reset();
    imem_req_ready = 1'b0;
    pend.push_back(32'h40);  // response with nothing in flight
    tick();
    tick();
    n_total++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL stray_count got=%0d exp=0", queue_count); end
    n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL stray_ivalid got=%h exp=0", instr_valid_f); end
    n_total++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL hold_req_valid got=%h exp=1", imem_req_valid); end
    n_total++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL hold_req_addr got=%h exp=0", imem_req_addr); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();                  // two requests in flight
    reset    = 1'b0;
    mem_hold = 1'b0;         // late responses arrive during reset
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid[%0d] got=%h exp=0", k, imem_req_valid); end
      n_total++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL mid_req_addr[%0d] got=%h exp=0", k, imem_req_addr); end
      n_total++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL mid_count[%0d] got=%0d exp=0", k, queue_count); end
      n_total++; if (instr_valid_f !== 1'b0) begin n_bad++; $display("FAIL mid_ivalid[%0d] got=%h exp=0", k, instr_valid_f); end
      n_total++; if (instr_f !== NOP) begin n_bad++; $display("FAIL mid_instr[%0d] got=%h exp=%h", k, instr_f, NOP); end
      n_total++; if (pc_f !== 32'h0) begin n_bad++; $display("FAIL mid_pc[%0d] got=%h exp=0", k, pc_f); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drain();
    test_redirect_full();
    test_wrap();
    test_stray_rsp();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: an instruction word is returned; in order, at most one per cycle, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits: the returned instruction word.
REQ-010 SHALL have port stall_f, input, 1 bit: the decode stage holds the current output.
REQ-011 SHALL have port redirect_valid, input, 1 bit: a taken branch or jump (pcsrc_e).
REQ-012 SHALL have port redirect_pc, input, 32 bits: the branch or jump target.
REQ-013 SHALL have port instr_f, output, 32 bits: instruction at the queue head, or NOP 32'h0000_0013 when the queue is empty.
REQ-014 SHALL have port pc_f, output, 32 bits: the PC of instr_f.
REQ-015 SHALL have port pcplus4_f, output, 32 bits: pc_f + 4, wrapping modulo 2^32.
REQ-016 SHALL have port instr_valid_f, output, 1 bit: the queue head holds a valid instruction.
REQ-017 SHALL have port queue_count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-018 SHALL keep a fetch-PC register; on each accepted request (imem_req_valid & imem_req_ready) the register SHALL advance by 4, modulo 2^32.
REQ-019 SHALL assert imem_req_valid only when queue_count + outstanding < DEPTH and redirect_valid = 0; outstanding is the number of accepted requests not yet responded to.
REQ-020 SHALL hold imem_req_valid and imem_req_addr stable until the request is accepted; the only permitted withdrawal is on redirect_valid.
REQ-021 SHALL implement a 2-state FSM:
  - FETCH: discard_cnt = 0; each response pushes {rsp_pc, imem_rsp_data} into the queue, and rsp_pc advances by 4.
  - DRAIN: discard_cnt > 0; each response is dropped and discard_cnt decrements.
  - DRAIN SHALL return to FETCH when discard_cnt reaches 0.
REQ-022 SHALL, on redirect_valid = 1:
  - clear the queue in the same edge;
  - load fetch-PC and rsp_pc with redirect_pc;
  - load discard_cnt with outstanding minus 1 if a response arrives in that cycle, else outstanding;
  - enter DRAIN if the loaded value is nonzero, else FETCH.
REQ-023 A response arriving in a redirect cycle SHALL be treated as stale and dropped.
REQ-024 Redirect SHALL override both pop and push in the same cycle.
REQ-025 SHALL pop the head when instr_valid_f = 1, stall_f = 0 and redirect_valid = 0.
REQ-026 Simultaneous push and pop SHALL leave queue_count unchanged.
REQ-027 Output latency SHALL be 1 cycle: a response pushed at edge N appears on instr_f after edge N when the queue was empty.
REQ-028 SHALL never push when full; credit accounting (REQ-019) guarantees this.
REQ-029 A response with outstanding = 0 SHALL be ignored.
REQ-030 Queue and counter pointers SHALL wrap modulo DEPTH; outstanding SHALL never exceed DEPTH.
REQ-031 instr_f, pc_f, pcplus4_f and instr_valid_f SHALL be combinational from the queue head register, with no memory-to-output combinational path.

Reset
REQ-032 While reset = 0 at a clock edge, the block SHALL set:
  - fetch-PC = rsp_pc = RESET_PC;
  - queue empty, outstanding = 0, discard_cnt = 0, FSM = FETCH.
REQ-033 During reset the outputs SHALL read imem_req_valid = 0, imem_req_addr = RESET_PC, instr_valid_f = 0, instr_f = 32'h0000_0013, pc_f = RESET_PC, queue_count = 0.
REQ-034 Reset mid-operation SHALL abandon all in-flight requests; responses arriving afterwards fall under REQ-029.
REQ-035 imem_req_valid SHALL first assert in the cycle after reset deasserts.

Verification
REQ-036 Stream: ready = 1, 1-cycle response latency, stall_f = 0 -> pc_f sequence 0, 4, 8, 12 on consecutive cycles with matching words; instr_valid_f = 1 from cycle 3.
REQ-037 Full: stall_f = 1 held for 10 cycles with DEPTH = 4 -> queue_count = 4, imem_req_valid = 0, no push is lost; after release, 4 consecutive pops in order.
REQ-038 Redirect with 3 outstanding and a response in the same cycle, redirect_pc = 32'h100 -> the next 2 responses are dropped, the first valid instr_f has pc_f = 32'h100, queue_count = 0 after the edge.
REQ-039 Redirect with stall_f = 1 and a full queue -> the queue clears, instr_valid_f = 0 the next cycle, and imem_req_addr = redirect_pc.
REQ-040 Wrap: RESET_PC = 32'hFFFF_FFF8 -> pc_f sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pcplus4_f = 0 at FFFF_FFFC.
REQ-041 Reset asserted with 2 outstanding, then 2 late responses -> all outputs hold their reset values and queue_count stays 0.
